otter_iobus_bridge: RTL

Parametrised memory-mapped I/O bridge between the OTTER MCU I/O bus and board peripherals. Decodes N_IN read ports and N_OUT write registers from two base addresses. Adds a buffered VRAM pixel-write FIFO with address auto-increment and ready/valid drain. Adds a synchronised, edge-detected button interrupt with write-1-to-clear pending bits. Sits between OTTER_MCU and the GPU/LED/segment/timer logic in the top-level wrapper.

---
 rtl/otter_iobus_bridge.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/otter_iobus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : otter_iobus_bridge
// Brief    : OTTER I/O bus decoder with output registers, buffered VRAM pixel
//            FIFO (auto-incrementing address) and synchronised button IRQ.
// Revision : 1.0 - initial release
// ============================================================================
module otter_iobus_bridge #(
  parameter logic [31:0] IN_BASE    = 32'h11008000,
  parameter logic [31:0] OUT_BASE   = 32'h1100C000,
  parameter int          N_IN       = 4,
  parameter int          N_OUT      = 8,
  parameter int          OUT_W      = 16,
  parameter int          N_BTN      = 5,
  parameter int          VADDR_W    = 15,
  parameter int          VDATA_W    = 8,
  parameter int          VRAM_WORDS = 2**VADDR_W,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            iobus_addr,
  input  logic [31:0]            iobus_out,
  input  logic                   iobus_wr,
  output logic [31:0]            iobus_in,
  input  logic [N_IN*32-1:0]     in_ports,
  input  logic [N_BTN-1:0]       btn,
  output logic [N_OUT*OUT_W-1:0] out_regs,
  output logic                   intr_o,
  output logic                   vram_we_o,
  output logic [VADDR_W-1:0]     vram_addr_o,
  output logic [VDATA_W-1:0]     vram_data_o,
  input  logic                   vram_ready_i
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = VADDR_W + VDATA_W;

  localparam logic [31:0] c_STATUS_A  = IN_BASE  + 32'(4 * N_IN);
  localparam logic [31:0] c_PIXADDR_A = OUT_BASE + 32'(4 * N_OUT);
  localparam logic [31:0] c_PIXDATA_A = OUT_BASE + 32'(4 * (N_OUT + 1));
  localparam logic [31:0] c_CTRL_A    = OUT_BASE + 32'(4 * (N_OUT + 2));

  localparam logic [VADDR_W-1:0] c_VADDR_LAST = VADDR_W'(VRAM_WORDS - 1);

  logic [OUT_W-1:0]   r_out [N_OUT];
  logic [VADDR_W-1:0] r_pixaddr;
  logic [1:0]         r_ctrl;
  logic [N_BTN-1:0]   r_pending;
  logic               r_overflow;
  logic               r_intr;
  logic [N_BTN-1:0]   r_sync1;
  logic [N_BTN-1:0]   r_sync2;
  logic [N_BTN-1:0]   r_btn_prev;

  logic [c_EW-1:0]    r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]    r_wr_ptr;
  logic [c_AW-1:0]    r_rd_ptr;
  logic [c_CW-1:0]    r_count;

  logic [N_OUT-1:0]   w_out_sel;
  logic               w_wr_pixaddr;
  logic               w_push_req;
  logic               w_wr_ctrl;
  logic               w_empty;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic [3:0]         w_cnt_disp;
  logic [31:0]        w_status;
  logic [31:0]        w_rdata;
  logic [N_BTN-1:0]   w_edge;
  logic [N_BTN-1:0]   w_clr;
  logic [c_EW-1:0]    w_head;
  logic               w_unused;

  assign w_unused = ^iobus_out;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_CW'(FIFO_DEPTH));
  assign w_pop      = ~w_empty & vram_ready_i;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_cnt_disp = (32'(r_count) > 32'd15) ? 4'hF : 4'(r_count);

  assign w_wr_pixaddr = iobus_wr & (iobus_addr == c_PIXADDR_A);
  assign w_push_req   = iobus_wr & (iobus_addr == c_PIXDATA_A);
  assign w_wr_ctrl    = iobus_wr & (iobus_addr == c_CTRL_A);

  assign w_edge = r_sync2 & ~r_btn_prev;
  assign w_clr  = w_wr_ctrl ? iobus_out[16 +: N_BTN] : '0;

  always_comb begin
    w_status                = '0;
    w_status[N_BTN-1:0]     = r_pending;
    w_status[16]            = w_empty;
    w_status[17]            = w_full;
    w_status[18]            = r_overflow;
    w_status[27:24]         = w_cnt_disp;
  end

  always_comb begin
    w_rdata   = '0;
    w_out_sel = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (iobus_addr == IN_BASE + 32'(4 * i)) w_rdata = in_ports[32*i +: 32];
    end
    for (int j = 0; j < N_OUT; j++) begin
      if (iobus_addr == OUT_BASE + 32'(4 * j)) begin
        w_rdata      = 32'(r_out[j]);
        w_out_sel[j] = 1'b1;
      end
    end
    if (iobus_addr == c_STATUS_A)  w_rdata = w_status;
    if (iobus_addr == c_PIXADDR_A) w_rdata = 32'(r_pixaddr);
    if (iobus_addr == c_CTRL_A)    w_rdata = 32'(r_ctrl);
  end

  assign iobus_in = w_rdata;

  generate
    for (genvar j = 0; j < N_OUT; j++) begin : g_out
      assign out_regs[OUT_W*j +: OUT_W] = r_out[j];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N_OUT; j++) r_out[j] <= '0;
      r_ctrl <= '0;
    end else begin
      for (int j = 0; j < N_OUT; j++) begin
        if (iobus_wr && w_out_sel[j]) r_out[j] <= iobus_out[OUT_W-1:0];
      end
      if (w_wr_ctrl) r_ctrl <= iobus_out[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pixaddr  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_pixaddr) begin
        r_pixaddr <= iobus_out[VADDR_W-1:0];
      end else if (w_push && r_ctrl[0]) begin
        r_pixaddr <= (r_pixaddr == c_VADDR_LAST) ? '0 : r_pixaddr + 1'b1;
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end else if (w_wr_ctrl && iobus_out[8]) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Storage is not reset; emptiness is tracked entirely by the pointers/count
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_pixaddr, iobus_out[VDATA_W-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head      = r_mem[r_rd_ptr];
  assign vram_we_o   = ~w_empty;
  assign vram_addr_o = w_head[c_EW-1:VDATA_W];
  assign vram_data_o = w_head[VDATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_btn_prev <= '0;
      r_pending  <= '0;
      r_intr     <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
      // OR-ing the edge in last lets a new press win over a same-cycle clear
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      r_intr     <= r_ctrl[1] & (|r_pending);
    end
  end

  assign intr_o = r_intr;

endmodule
`default_nettype wire
